xbar_banks_pea_bb_pipe: RTL and testbench
=========================================

# xbar_banks_pea_bb_pipe

Pipelined, parametrised basic block of the banks↔PE-array crossbar. It selects one of N_BANKS bank read ports towards a single PE input, and one of N_PE PE outputs towards a single bank write port. Each direction has a configurable register pipeline with per-word valid tracking and a double-buffered (shadow/active) selector configuration. It sits between the scratchpad bank group and the PE array, one instance per crossbar lane.

## Interface
Parameters:
- N_PE, 4, PE outputs visible to this block (≥2)
- N_BANKS, 4, bank read ports visible to this block (≥2)
- N_BITS, 32, datapath word width
- PIPE_DEPTH, 2, register stages per direction (1..4); this is the latency in cycles
- SEL_PE_W, $clog2(N_PE), derived, PE selector width
- SEL_BK_W, $clog2(N_BANKS), derived, bank selector width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- cfg_we_i  in  1  write shadow selectors
- cfg_sel_dmem_pea_i  in  SEL_BK_W  shadow bank selector (bank→PE direction)
- cfg_sel_pea_dmem_i  in  SEL_PE_W  shadow PE selector (PE→bank direction)
- cfg_commit_i  in  1  copy shadow into active selectors
- stall_i  in  1  freeze both pipelines
- flush_i  in  1  invalidate all in-flight words
- out_pea_bb_i  in  N_PE×N_BITS  PE output words
- out_pea_valid_i  in  N_PE  per-PE valid
- out_dmem_bb_i  in  N_BANKS×N_BITS  bank read words
- out_dmem_valid_i  in  N_BANKS  per-bank valid
- in_pea_bb_o  out  N_BITS  word to PE
- in_pea_valid_o  out  1  valid of in_pea_bb_o
- in_dmem_bb_o  out  N_BITS  word to bank
- in_dmem_valid_o  out  1  valid of in_dmem_bb_o
- cfg_active_sel_o  out  SEL_BK_W+SEL_PE_W  active selectors {dmem_pea, pea_dmem}, for debug

## Operation
- Shadow registers: cfg_we_i=1 loads both shadow selectors at the clock edge.
- Active registers: cfg_commit_i=1 copies the pre-edge shadow values into active. With cfg_we_i and cfg_commit_i in the same cycle, active takes the old shadow and shadow takes the new value.
- Stage 0 muxes on the active selectors. Bank→PE: data=out_dmem_bb_i[sel], valid=out_dmem_valid_i[sel]. PE→bank is symmetric.
- When N_PE or N_BANKS is not a power of two, a selector ≥ N selects data 0 with valid 0.
- Each stage register holds {valid, data}. A word travels PIPE_DEPTH stages. Its selection is fixed at stage 0, so a commit never alters words already in flight.
- When a stage's valid is 0, its data register still loads but is don't-care. Outputs present the last stage directly.
- Priority at each edge: reset > flush > stall > advance.
  - flush_i clears every stage valid, including the word being sampled this cycle. Data is left as-is.
  - stall_i holds every stage and ignores inputs. Config writes and commits still apply during stall.
  - flush_i together with stall_i: flush wins, valids clear.
- The two directions are independent data paths. They share the stall, flush and config controls.

## Timing
- Reset values: all stage valids=0, all stage data=0, shadow=0, active=0. Hence in_pea_valid_o=0, in_dmem_valid_o=0, both data outputs=0, cfg_active_sel_o=0.
- Latency: a word sampled at edge k appears on the outputs after edge k+PIPE_DEPTH-1. That is PIPE_DEPTH cycles from input to output with no stalls.
- Throughput: one word per cycle per direction.
- Commit at edge k: words sampled at edge k+1 onward use the new selectors. The word sampled at edge k uses the old selectors.
- Stall: each stalled cycle adds exactly one cycle of latency to every in-flight word. Outputs stay constant during the stall.
- Flush at edge k: outputs are invalid from edge k until new valid words propagate. The first valid output is at edge k+PIPE_DEPTH at the earliest.
- Reset asserted mid-stream: all outputs are 0 asynchronously. After deassertion the pipeline starts empty.

## Test plan
- Reset, then commit sel_dmem_pea=2 and drive bank2=0xA5A5_0001 valid with PIPE_DEPTH=2 → in_pea_bb_o=0xA5A5_0001 with valid=1 exactly 2 cycles after sampling; the other banks have no effect.
- Stream bank1 words 1,2,3,… with sel=1. Issue cfg_we sel=3 followed by cfg_commit mid-stream → words before the commit edge come from bank1, words after come from bank3, no word is lost or duplicated, and latency is unchanged.
- cfg_we_i and cfg_commit_i in the same cycle, with shadow previously 1 and new value 2 → cfg_active_sel_o shows 1 after the edge; a second commit shows 2.
- Stall for 3 cycles with 2 words in flight → outputs frozen for 3 cycles, then words 1,2 emerge in order with no loss.
- Flush with a full pipeline, including a simultaneous stall → both valid outputs drop to 0 for PIPE_DEPTH cycles, and no stale word ever appears with valid=1.
- N_BANKS=3 with active selector 3 and all bank valids=1 → in_pea_valid_o=0 and in_pea_bb_o=0. Then assert rst_n_i=0 mid-stream → all outputs go to 0 immediately.

Source files
------------

// File: rtl/xbar_banks_pea_bb_pipe.sv
// Banks<->PE-array crossbar basic block: one bank->PE and one PE->bank lane,
// each a registered selector mux followed by a valid-tracked pipeline.

module xbar_banks_pea_bb_lane #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_SRC*N_BITS-1:0] data_i,
  input  logic [N_SRC-1:0]        valid_i,
  output logic [N_BITS-1:0]       data_o,
  output logic                    valid_o
);

  logic [N_SRC-1:0]  hit;
  logic [N_BITS-1:0] acc [N_SRC+1];
  logic [N_BITS-1:0] mux_dat;
  logic              mux_vld;

  logic [N_BITS-1:0] dat_q [PIPE_DEPTH];
  logic              vld_q [PIPE_DEPTH];

  // One-hot decode OR-reduced; a selector with no matching source yields 0/invalid.
  assign acc[0] = '0;
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign hit[g]   = (sel == SEL_W'(g));
    assign acc[g+1] = acc[g] | (hit[g] ? data_i[g*N_BITS +: N_BITS] : '0);
  end

  assign mux_dat = acc[N_SRC];
  assign mux_vld = |(hit & valid_i);

  for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
    logic [N_BITS-1:0] d_in;
    logic              v_in;

    if (s == 0) begin : g_head
      assign d_in = mux_dat;
      assign v_in = mux_vld;
    end else begin : g_body
      assign d_in = dat_q[s-1];
      assign v_in = vld_q[s-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[s] <= 1'b0;
        dat_q[s] <= '0;
      end else if (flush) begin
        vld_q[s] <= 1'b0;
      end else if (!stall) begin
        vld_q[s] <= v_in;
        dat_q[s] <= d_in;
      end
    end
  end

  assign data_o  = dat_q[PIPE_DEPTH-1];
  assign valid_o = vld_q[PIPE_DEPTH-1];

endmodule

module xbar_banks_pea_bb_pipe #(
  parameter int unsigned N_PE       = 4,
  parameter int unsigned N_BANKS    = 4,
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned SEL_PE_W   = $clog2(N_PE),
  parameter int unsigned SEL_BK_W   = $clog2(N_BANKS)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cfg_we_i,
  input  logic [SEL_BK_W-1:0]          cfg_sel_dmem_pea_i,
  input  logic [SEL_PE_W-1:0]          cfg_sel_pea_dmem_i,
  input  logic                         cfg_commit_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [N_PE*N_BITS-1:0]       out_pea_bb_i,
  input  logic [N_PE-1:0]              out_pea_valid_i,
  input  logic [N_BANKS*N_BITS-1:0]    out_dmem_bb_i,
  input  logic [N_BANKS-1:0]           out_dmem_valid_i,
  output logic [N_BITS-1:0]            in_pea_bb_o,
  output logic                         in_pea_valid_o,
  output logic [N_BITS-1:0]            in_dmem_bb_o,
  output logic                         in_dmem_valid_o,
  output logic [SEL_BK_W+SEL_PE_W-1:0] cfg_active_sel_o
);

  logic [SEL_BK_W-1:0] shd_bk, act_bk;
  logic [SEL_PE_W-1:0] shd_pe, act_pe;

  // Commit reads the pre-edge shadow, so a same-cycle write lands one commit later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shd_bk <= '0;
      shd_pe <= '0;
      act_bk <= '0;
      act_pe <= '0;
    end else begin
      if (cfg_commit_i) begin
        act_bk <= shd_bk;
        act_pe <= shd_pe;
      end
      if (cfg_we_i) begin
        shd_bk <= cfg_sel_dmem_pea_i;
        shd_pe <= cfg_sel_pea_dmem_i;
      end
    end
  end

  assign cfg_active_sel_o = {act_bk, act_pe};

  xbar_banks_pea_bb_lane #(
    .N_SRC      (N_BANKS),
    .N_BITS     (N_BITS),
    .PIPE_DEPTH (PIPE_DEPTH),
    .SEL_W      (SEL_BK_W)
  ) u_dmem_to_pea (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .stall   (stall_i),
    .flush   (flush_i),
    .sel     (act_bk),
    .data_i  (out_dmem_bb_i),
    .valid_i (out_dmem_valid_i),
    .data_o  (in_pea_bb_o),
    .valid_o (in_pea_valid_o)
  );

  xbar_banks_pea_bb_lane #(
    .N_SRC      (N_PE),
    .N_BITS     (N_BITS),
    .PIPE_DEPTH (PIPE_DEPTH),
    .SEL_W      (SEL_PE_W)
  ) u_pea_to_dmem (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .stall   (stall_i),
    .flush   (flush_i),
    .sel     (act_pe),
    .data_i  (out_pea_bb_i),
    .valid_i (out_pea_valid_i),
    .data_o  (in_dmem_bb_o),
    .valid_o (in_dmem_valid_o)
  );

endmodule

// File: tb/tb_xbar_banks_pea_bb_pipe.sv
// Directed bench for xbar_banks_pea_bb_pipe: a 4x4 instance and a 3-bank instance, depth 2.

module tb_xbar_banks_pea_bb_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_we, cfg_commit, stall, flush;
  logic [1:0]  sel_bk, sel_pe;
  logic [127:0] pea_bb;
  logic [3:0]   pea_vld;
  logic [127:0] dmem_bb;
  logic [3:0]   dmem_vld;
  logic [95:0]  dmem3_bb;
  logic [2:0]   dmem3_vld;

  logic [31:0] in_pea_bb, in_dmem_bb, in_pea_bb3, in_dmem_bb3;
  logic        in_pea_vld, in_dmem_vld, in_pea_vld3, in_dmem_vld3;
  logic [3:0]  act, act3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbar_banks_pea_bb_pipe #(
    .N_PE(4), .N_BANKS(4), .N_BITS(32), .PIPE_DEPTH(2)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .cfg_we_i           (cfg_we),
    .cfg_sel_dmem_pea_i (sel_bk),
    .cfg_sel_pea_dmem_i (sel_pe),
    .cfg_commit_i       (cfg_commit),
    .stall_i            (stall),
    .flush_i            (flush),
    .out_pea_bb_i       (pea_bb),
    .out_pea_valid_i    (pea_vld),
    .out_dmem_bb_i      (dmem_bb),
    .out_dmem_valid_i   (dmem_vld),
    .in_pea_bb_o        (in_pea_bb),
    .in_pea_valid_o     (in_pea_vld),
    .in_dmem_bb_o       (in_dmem_bb),
    .in_dmem_valid_o    (in_dmem_vld),
    .cfg_active_sel_o   (act)
  );

  xbar_banks_pea_bb_pipe #(
    .N_PE(4), .N_BANKS(3), .N_BITS(32), .PIPE_DEPTH(2)
  ) dut3 (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .cfg_we_i           (cfg_we),
    .cfg_sel_dmem_pea_i (sel_bk),
    .cfg_sel_pea_dmem_i (sel_pe),
    .cfg_commit_i       (cfg_commit),
    .stall_i            (stall),
    .flush_i            (flush),
    .out_pea_bb_i       (pea_bb),
    .out_pea_valid_i    (pea_vld),
    .out_dmem_bb_i      (dmem3_bb),
    .out_dmem_valid_i   (dmem3_vld),
    .in_pea_bb_o        (in_pea_bb3),
    .in_pea_valid_o     (in_pea_vld3),
    .in_dmem_bb_o       (in_dmem_bb3),
    .in_dmem_valid_o    (in_dmem_vld3),
    .cfg_active_sel_o   (act3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_pea_vld !== 1'b0 || in_pea_bb !== 32'h0 || in_dmem_vld !== 1'b0 ||
        in_dmem_bb !== 32'h0 || act !== 4'h0) begin
      errors++;
      $display("FAIL reset_main: got pv=%b pd=%h dv=%b dd=%h act=%h, want all 0",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb, act);
    end
    checks++;
    if (in_pea_vld3 !== 1'b0 || in_pea_bb3 !== 32'h0 || in_dmem_vld3 !== 1'b0 ||
        in_dmem_bb3 !== 32'h0 || act3 !== 4'h0) begin
      errors++;
      $display("FAIL reset_n3: got pv=%b pd=%h dv=%b dd=%h act=%h, want all 0",
               in_pea_vld3, in_pea_bb3, in_dmem_vld3, in_dmem_bb3, act3);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    sel_bk = 2'd2; sel_pe = 2'd1; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    checks++;
    if (act !== 4'h9) begin
      errors++;
      $display("FAIL basic_active: got %h want %h", act, 4'h9);
    end
    dmem_bb = {32'h0000_00B3, 32'hA5A5_0001, 32'h0000_00B1, 32'h0000_00B0};
    dmem_vld = 4'b1111;
    pea_bb = {32'h0000_00C3, 32'h0000_00C2, 32'hBEEF_0001, 32'h0000_00C0};
    pea_vld = 4'b1111;
    step();
    dmem_bb = {4{32'hFFFF_0000}}; dmem_vld = 4'b0000;
    pea_bb = {4{32'hFFFF_1111}}; pea_vld = 4'b0000;
    checks++;
    if (in_pea_vld !== 1'b0 || in_dmem_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got pv=%b dv=%b want 0 0", in_pea_vld, in_dmem_vld);
    end
    step();
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'hA5A5_0001 ||
        in_dmem_vld !== 1'b1 || in_dmem_bb !== 32'hBEEF_0001) begin
      errors++;
      $display("FAIL basic_data: got pv=%b pd=%h dv=%b dd=%h want 1 a5a50001 1 beef0001",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
    end
    step();
    checks++;
    if (in_pea_vld !== 1'b0 || in_dmem_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_tail: got pv=%b dv=%b want 0 0", in_pea_vld, in_dmem_vld);
    end
  endtask

  task automatic test_commit_stream();
    logic [31:0] exp;
    sel_bk = 2'd1; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    pea_vld = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      dmem_bb = '0;
      dmem_bb[32 +: 32] = 32'h100 + 32'(n);
      dmem_bb[96 +: 32] = 32'h300 + 32'(n);
      dmem_vld = 4'b1111;
      cfg_we = (n == 3);
      if (n == 3) sel_bk = 2'd3;
      cfg_commit = (n == 4);
      step();
      if (n >= 1) begin
        exp = (n - 1 <= 4) ? 32'h100 + 32'(n - 1) : 32'h300 + 32'(n - 1);
        checks++;
        if (in_pea_vld !== 1'b1 || in_pea_bb !== exp) begin
          errors++;
          $display("FAIL stream_word%0d: got v=%b d=%h want v=1 d=%h",
                   n - 1, in_pea_vld, in_pea_bb, exp);
        end
      end
    end
    cfg_we = 1'b0; cfg_commit = 1'b0; dmem_vld = 4'b0000;
    step();
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h309) begin
      errors++;
      $display("FAIL stream_word9: got v=%b d=%h want v=1 d=309", in_pea_vld, in_pea_bb);
    end
    step();
  endtask

  task automatic test_we_commit_same();
    sel_bk = 2'd1; cfg_we = 1'b1;
    step();
    sel_bk = 2'd2; cfg_we = 1'b1; cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0;
    checks++;
    if (act !== 4'h5) begin
      errors++;
      $display("FAIL same_cycle_commit: got %h want %h", act, 4'h5);
    end
    step();
    cfg_commit = 1'b0;
    checks++;
    if (act !== 4'h9) begin
      errors++;
      $display("FAIL second_commit: got %h want %h", act, 4'h9);
    end
  endtask

  task automatic test_stall();
    dmem_bb = '0; pea_bb = '0;
    dmem_bb[64 +: 32] = 32'h1; dmem_vld = 4'b0100;
    pea_bb[32 +: 32] = 32'hE1; pea_vld = 4'b0010;
    step();
    dmem_bb[64 +: 32] = 32'h2;
    pea_bb[32 +: 32] = 32'hE2;
    step();
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h1 || in_dmem_vld !== 1'b1 || in_dmem_bb !== 32'hE1) begin
      errors++;
      $display("FAIL stall_pre: got pv=%b pd=%h dv=%b dd=%h want 1 1 1 e1",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
    end
    stall = 1'b1;
    dmem_bb[64 +: 32] = 32'hDEAD; pea_bb[32 +: 32] = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h1 || in_dmem_vld !== 1'b1 || in_dmem_bb !== 32'hE1) begin
        errors++;
        $display("FAIL stall_hold%0d: got pv=%b pd=%h dv=%b dd=%h want 1 1 1 e1",
                 c, in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
      end
    end
    stall = 1'b0; dmem_vld = 4'b0000; pea_vld = 4'b0000;
    step();
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h2 || in_dmem_vld !== 1'b1 || in_dmem_bb !== 32'hE2) begin
      errors++;
      $display("FAIL stall_resume: got pv=%b pd=%h dv=%b dd=%h want 1 2 1 e2",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
    end
    step();
    checks++;
    if (in_pea_vld !== 1'b0 || in_dmem_vld !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got pv=%b dv=%b want 0 0", in_pea_vld, in_dmem_vld);
    end
  endtask

  task automatic test_flush();
    dmem_bb = '0; pea_bb = '0;
    dmem_bb[64 +: 32] = 32'h11; dmem_vld = 4'b0100;
    pea_bb[32 +: 32] = 32'h61; pea_vld = 4'b0010;
    step();
    dmem_bb[64 +: 32] = 32'h22; pea_bb[32 +: 32] = 32'h62;
    step();
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h11 || in_dmem_vld !== 1'b1 || in_dmem_bb !== 32'h61) begin
      errors++;
      $display("FAIL flush_fill: got pv=%b pd=%h dv=%b dd=%h want 1 11 1 61",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
    end
    dmem_bb[64 +: 32] = 32'h33; pea_bb[32 +: 32] = 32'h63;
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    checks++;
    if (in_pea_vld !== 1'b0 || in_dmem_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_edge: got pv=%b dv=%b want 0 0", in_pea_vld, in_dmem_vld);
    end
    dmem_bb[64 +: 32] = 32'h44; pea_bb[32 +: 32] = 32'h64;
    step();
    checks++;
    if (in_pea_vld !== 1'b0 || in_dmem_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale: got pv=%b pd=%h dv=%b dd=%h want both invalid",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
    end
    dmem_vld = 4'b0000; pea_vld = 4'b0000;
    step();
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h44 || in_dmem_vld !== 1'b1 || in_dmem_bb !== 32'h64) begin
      errors++;
      $display("FAIL flush_refill: got pv=%b pd=%h dv=%b dd=%h want 1 44 1 64",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb);
    end
  endtask

  task automatic test_nonpow2_and_reset();
    sel_bk = 2'd3; sel_pe = 2'd1; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    dmem3_bb = {32'hC2, 32'hC1, 32'hC0}; dmem3_vld = 3'b111;
    dmem_bb = {32'h33, 32'h22, 32'h11, 32'h10}; dmem_vld = 4'b1111;
    pea_bb = '0; pea_bb[32 +: 32] = 32'h71; pea_vld = 4'b0010;
    step();
    step();
    checks++;
    if (in_pea_vld3 !== 1'b0 || in_pea_bb3 !== 32'h0) begin
      errors++;
      $display("FAIL n3_out_of_range: got v=%b d=%h want 0 0", in_pea_vld3, in_pea_bb3);
    end
    checks++;
    if (in_dmem_vld3 !== 1'b1 || in_dmem_bb3 !== 32'h71) begin
      errors++;
      $display("FAIL n3_pe_side: got v=%b d=%h want 1 71", in_dmem_vld3, in_dmem_bb3);
    end
    checks++;
    if (in_pea_vld !== 1'b1 || in_pea_bb !== 32'h33) begin
      errors++;
      $display("FAIL main_bank3: got v=%b d=%h want 1 33", in_pea_vld, in_pea_bb);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_pea_vld !== 1'b0 || in_pea_bb !== 32'h0 || in_dmem_vld !== 1'b0 ||
        in_dmem_bb !== 32'h0 || act !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_main: got pv=%b pd=%h dv=%b dd=%h act=%h want all 0",
               in_pea_vld, in_pea_bb, in_dmem_vld, in_dmem_bb, act);
    end
    checks++;
    if (in_pea_vld3 !== 1'b0 || in_dmem_vld3 !== 1'b0 || in_dmem_bb3 !== 32'h0 || act3 !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_n3: got pv=%b dv=%b dd=%h act=%h want all 0",
               in_pea_vld3, in_dmem_vld3, in_dmem_bb3, act3);
    end
    dmem_vld = 4'b0000; dmem3_vld = 3'b000; pea_vld = 4'b0000;
    #1 rst_n = 1'b1;
    step();
    step();
    checks++;
    if (in_pea_vld !== 1'b0 || in_dmem_vld !== 1'b0 || act !== 4'h0) begin
      errors++;
      $display("FAIL post_reset_empty: got pv=%b dv=%b act=%h want 0 0 0",
               in_pea_vld, in_dmem_vld, act);
    end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_commit = 1'b0; stall = 1'b0; flush = 1'b0;
    sel_bk = 2'd0; sel_pe = 2'd0;
    pea_bb = '0; pea_vld = '0;
    dmem_bb = '0; dmem_vld = '0;
    dmem3_bb = '0; dmem3_vld = '0;
    test_reset();
    test_basic();
    test_commit_stream();
    test_we_commit_same();
    test_stall();
    test_flush();
    test_nonpow2_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
